cnt_tick_ctrl: RTL and testbench

Upstream controller for the game's reload down-counter (CntS). It drives the counter's synchronous clear, its enable (ce) and its reload value (d), and reads back the counter value q. It turns the system clock into prescaled ticks and runs a start/pause/stop FSM with one-shot or auto-reload modes, so game timers (countdowns, spawn intervals) come from the pixel clock without extra glue logic.

---
 rtl/cnt_tick_ctrl.sv | 113 +++++++++++
 tb/tb_cnt_tick_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_tick_ctrl.sv
// Tick/FSM controller for a reload down-counter: clears, loads and decrements
// the counter once per DIV clocks, in one-shot or auto-reload mode.
module cnt_tick_ctrl #(
  parameter int WIDTH = 16,
  parameter int PRE_W = 16,
  parameter int DIV   = 25000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             pause_i,
  input  logic             auto_i,
  input  logic [WIDTH-1:0] period_i,
  input  logic [WIDTH-1:0] q_i,
  output logic             cnt_rst_n_o,
  output logic             ce_o,
  output logic [WIDTH-1:0] d_o,
  output logic             wrap_o,
  output logic             done_o,
  output logic             busy_o,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    PAUSE = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  state_t           state;
  logic [PRE_W-1:0] presc;
  logic             auto_q;

  assign state_o = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      presc       <= '0;
      auto_q      <= 1'b0;
      d_o         <= '0;
      ce_o        <= 1'b0;
      wrap_o      <= 1'b0;
      done_o      <= 1'b0;
      cnt_rst_n_o <= 1'b1;
      busy_o      <= 1'b0;
    end else begin
      ce_o        <= 1'b0;
      wrap_o      <= 1'b0;
      done_o      <= 1'b0;
      cnt_rst_n_o <= 1'b1;
      if (stop_i) begin
        state  <= IDLE;
        busy_o <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start_i) begin
              d_o         <= period_i;
              auto_q      <= auto_i;
              state       <= ARM;
              cnt_rst_n_o <= 1'b0;
              busy_o      <= 1'b1;
            end
          end
          ARM: begin
            state <= LOAD;
            ce_o  <= 1'b1;
          end
          LOAD: begin
            state <= RUN;
            presc <= '0;
          end
          // Leaving PAUSE counts that cycle as a normal RUN cycle, so a pause
          // held for N cycles delays every later tick by exactly N cycles.
          RUN, PAUSE: begin
            if (pause_i) begin
              state <= PAUSE;
            end else begin
              state <= RUN;
              if (presc == PRE_LAST) begin
                presc <= '0;
                if (q_i != '0) begin
                  ce_o <= 1'b1;
                end else if (auto_q) begin
                  ce_o   <= 1'b1;
                  wrap_o <= 1'b1;
                end else begin
                  done_o <= 1'b1;
                  state  <= DONE;
                  busy_o <= 1'b0;
                end
              end else begin
                presc <= presc + PRE_W'(1);
              end
            end
          end
          default: begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cnt_tick_ctrl.sv
// Bench for cnt_tick_ctrl with a reload down-counter model attached to each instance.
module tb_cnt_tick_ctrl;
  localparam int W  = 16;
  localparam int D  = 4;
  localparam int W2 = 8;
  localparam int D2 = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0, stop_i = 1'b0, pause_i = 1'b0, auto_i = 1'b0;
  logic [W-1:0]  period_i = '0;
  logic [W-1:0]  q = '0;
  logic          cnt_rst_n, ce, wrap, done, busy;
  logic [W-1:0]  d;
  logic [2:0]    state;

  logic          start2 = 1'b0;
  logic [W2-1:0] period2 = '0;
  logic [W2-1:0] q2 = '0;
  logic          cnt_rst_n2, ce2, wrap2, done2, busy2;
  logic [W2-1:0] d2;
  logic [2:0]    state2;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] wrap_q[$];

  always #5 clk = ~clk;

  cnt_tick_ctrl #(.WIDTH(W), .PRE_W(16), .DIV(D)) u_dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .stop_i(stop_i), .pause_i(pause_i),
    .auto_i(auto_i), .period_i(period_i), .q_i(q), .cnt_rst_n_o(cnt_rst_n), .ce_o(ce),
    .d_o(d), .wrap_o(wrap), .done_o(done), .busy_o(busy), .state_o(state)
  );

  cnt_tick_ctrl #(.WIDTH(W2), .PRE_W(8), .DIV(D2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start_i(start2), .stop_i(stop_i), .pause_i(pause_i),
    .auto_i(auto_i), .period_i(period2), .q_i(q2), .cnt_rst_n_o(cnt_rst_n2), .ce_o(ce2),
    .d_o(d2), .wrap_o(wrap2), .done_o(done2), .busy_o(busy2), .state_o(state2)
  );

  // CntS: sync clear, on ce reload d at zero else decrement
  always @(posedge clk) begin
    if (!cnt_rst_n) q <= '0;
    else if (ce) q <= (q == '0) ? d : q - W'(1);
    if (!cnt_rst_n2) q2 <= '0;
    else if (ce2) q2 <= (q2 == '0) ? d2 : q2 - W2'(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [W-1:0] p, input logic a);
    period_i = p;
    auto_i   = a;
    start_i  = 1'b1;
    step();
    start_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if ({ce, wrap, done, busy} !== 4'b0000) begin errors++; $display("FAIL reset_pulses: got %b want 0000", {ce, wrap, done, busy}); end
    checks++; if (cnt_rst_n !== 1'b1 || d !== '0) begin errors++; $display("FAIL reset_cnt: cnt_rst_n=%b d=%0d want 1 0", cnt_rst_n, d); end
    rst_n = 1'b1;
    step();
    pulse_start(16'd5, 1'b0);
    repeat (8) step();
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL mid_run_state: got %0d want 3", state); end
    rst_n = 1'b0;
    step();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_mid_state: got %0d want 0", state); end
    checks++; if ({ce, wrap, done, busy} !== 4'b0000) begin errors++; $display("FAIL reset_mid_pulses: got %b want 0000", {ce, wrap, done, busy}); end
    checks++; if (cnt_rst_n !== 1'b1 || d !== '0) begin errors++; $display("FAIL reset_mid_cnt: cnt_rst_n=%b d=%0d want 1 0", cnt_rst_n, d); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (state !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL reset_release: state=%0d busy=%b want 0 0", state, busy); end
  endtask

  task automatic test_oneshot();
    int done_k;
    logic [31:0] e;
    done_k = -1;
    exp_q.delete();
    exp_q.push_back(32'd1);
    for (int j = 1; j <= 3; j++) exp_q.push_back(32'(2 + D * j));
    pulse_start(16'd3, 1'b0);
    checks++; if (cnt_rst_n !== 1'b0 || state !== 3'd1) begin errors++; $display("FAIL os_arm: cnt_rst_n=%b state=%0d want 0 1", cnt_rst_n, state); end
    checks++; if (d !== 16'd3) begin errors++; $display("FAIL os_latch: d=%0d want 3", d); end
    for (int k = 0; k < 30; k++) begin
      if (ce === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL os_ce: ce=1 want 0 at cycle %0d", k); end
        else begin
          e = exp_q.pop_front();
          if (32'(k) !== e) begin errors++; $display("FAIL os_ce: at cycle %0d want cycle %0d", k, e); end
        end
      end
      if (done === 1'b1) begin
        checks++;
        if (k !== 18 || state !== 3'd5) begin errors++; $display("FAIL os_done: cycle=%0d state=%0d want 18 5", k, state); end
        done_k = k;
      end
      if (k == 2) begin
        checks++; if (q !== 16'd3) begin errors++; $display("FAIL os_load: q=%0d want 3", q); end
      end
      step();
    end
    checks++; if (exp_q.size() != 0 || done_k < 0) begin errors++; $display("FAIL os_end: missing ce=%0d done_cycle=%0d want 0 18", exp_q.size(), done_k); end
    checks++; if (state !== 3'd5 || q !== '0 || busy !== 1'b0) begin errors++; $display("FAIL os_final: state=%0d q=%0d busy=%b want 5 0 0", state, q, busy); end
  endtask

  task automatic test_pause();
    int done_k;
    logic [31:0] e;
    done_k = -1;
    exp_q.delete();
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd6);
    exp_q.push_back(32'd20);
    exp_q.push_back(32'd24);
    pulse_start(16'd3, 1'b0);
    for (int k = 0; k < 34; k++) begin
      if (ce === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL pause_ce: ce=1 want 0 at cycle %0d", k); end
        else begin
          e = exp_q.pop_front();
          if (32'(k) !== e) begin errors++; $display("FAIL pause_ce: at cycle %0d want cycle %0d", k, e); end
        end
      end
      if (done === 1'b1) begin
        checks++;
        if (k !== 28) begin errors++; $display("FAIL pause_done: cycle=%0d want 28", k); end
        done_k = k;
      end
      if (k == 10) begin
        checks++; if (state !== 3'd4 || busy !== 1'b1) begin errors++; $display("FAIL pause_state: state=%0d busy=%b want 4 1", state, busy); end
      end
      if (k == 6) pause_i = 1'b1;
      if (k == 16) pause_i = 1'b0;
      step();
    end
    checks++; if (exp_q.size() != 0 || done_k < 0) begin errors++; $display("FAIL pause_end: missing ce=%0d done_cycle=%0d want 0 28", exp_q.size(), done_k); end
  endtask

  task automatic test_auto();
    int chk_k;
    logic [31:0] e;
    chk_k = -1;
    exp_q.delete();
    wrap_q.delete();
    exp_q.push_back(32'd1);
    for (int t = 6; t <= 40; t += D) exp_q.push_back(32'(t));
    wrap_q.push_back(32'd14);
    wrap_q.push_back(32'd26);
    wrap_q.push_back(32'd38);
    pulse_start(16'd2, 1'b1);
    for (int k = 0; k < 42; k++) begin
      if (ce === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL auto_ce: ce=1 want 0 at cycle %0d", k); end
        else begin
          e = exp_q.pop_front();
          if (32'(k) !== e) begin errors++; $display("FAIL auto_ce: at cycle %0d want cycle %0d", k, e); end
        end
      end
      if (wrap === 1'b1) begin
        checks++;
        if (wrap_q.size() == 0) begin errors++; $display("FAIL auto_wrap: wrap=1 want 0 at cycle %0d", k); end
        else begin
          e = wrap_q.pop_front();
          if (32'(k) !== e || ce !== 1'b1) begin errors++; $display("FAIL auto_wrap: cycle=%0d ce=%b want %0d 1", k, ce, e); end
        end
        chk_k = k + 1;
      end
      if (k == chk_k) begin
        checks++; if (q !== 16'd2) begin errors++; $display("FAIL auto_reload: q=%0d want 2 at cycle %0d", q, k); end
      end
      if (done === 1'b1) begin
        checks++; errors++; $display("FAIL auto_done: done=1 want 0 at cycle %0d", k);
      end
      step();
    end
    checks++; if (exp_q.size() != 0 || wrap_q.size() != 0) begin errors++; $display("FAIL auto_end: missing ce=%0d wrap=%0d want 0 0", exp_q.size(), wrap_q.size()); end
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    checks++; if (state !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL auto_stop: state=%0d busy=%b want 0 0", state, busy); end
  endtask

  task automatic test_abort();
    int pulses;
    pulses = 0;
    pulse_start(16'd3, 1'b0);
    repeat (9) step();
    stop_i   = 1'b1;
    start_i  = 1'b1;
    period_i = 16'd7;
    step();
    stop_i  = 1'b0;
    start_i = 1'b0;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL abort_state: got %0d want 0", state); end
    checks++; if ({ce, wrap, done, busy} !== 4'b0000) begin errors++; $display("FAIL abort_pulses: got %b want 0000", {ce, wrap, done, busy}); end
    for (int k = 0; k < 20; k++) begin
      if (ce === 1'b1 || done === 1'b1 || wrap === 1'b1) pulses++;
      step();
    end
    checks++; if (pulses != 0 || state !== 3'd0) begin errors++; $display("FAIL abort_quiet: pulses=%0d state=%0d want 0 0", pulses, state); end
  endtask

  task automatic test_back_to_back();
    int done_k;
    int ces;
    done_k = -1;
    pulse_start(16'd1, 1'b0);
    for (int k = 0; k < 14; k++) begin
      if (done === 1'b1) done_k = k;
      step();
    end
    checks++; if (done_k !== 10 || state !== 3'd5) begin errors++; $display("FAIL b2b_first: done_cycle=%0d state=%0d want 10 5", done_k, state); end
    done_k = -1;
    ces = 0;
    pulse_start(16'd2, 1'b0);
    checks++; if (state !== 3'd1 || d !== 16'd2) begin errors++; $display("FAIL b2b_restart: state=%0d d=%0d want 1 2", state, d); end
    for (int k = 0; k < 20; k++) begin
      if (ce === 1'b1) ces++;
      if (done === 1'b1) done_k = k;
      step();
    end
    checks++; if (done_k !== 14 || ces !== 3) begin errors++; $display("FAIL b2b_second: done_cycle=%0d ce_count=%0d want 14 3", done_k, ces); end
  endtask

  task automatic test_period_zero();
    int done_k;
    logic [31:0] e;
    done_k = -1;
    exp_q.delete();
    exp_q.push_back(32'd1);
    pulse_start(16'd0, 1'b0);
    for (int k = 0; k < 15; k++) begin
      if (ce === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL zero_ce: ce=1 want 0 at cycle %0d", k); end
        else begin
          e = exp_q.pop_front();
          if (32'(k) !== e) begin errors++; $display("FAIL zero_ce: at cycle %0d want cycle %0d", k, e); end
        end
      end
      if (done === 1'b1) done_k = k;
      step();
    end
    checks++; if (done_k !== 6 || exp_q.size() != 0) begin errors++; $display("FAIL zero_done: done_cycle=%0d missing ce=%0d want 6 0", done_k, exp_q.size()); end
  endtask

  task automatic test_period_max();
    int done_k;
    int bad;
    logic [W2-1:0] prev;
    logic [31:0] e;
    done_k = -1;
    bad = 0;
    prev = '0;
    exp_q.delete();
    exp_q.push_back(32'd1);
    for (int j = 1; j <= 255; j++) exp_q.push_back(32'(2 + D2 * j));
    period2 = 8'd255;
    auto_i  = 1'b0;
    start2  = 1'b1;
    step();
    start2  = 1'b0;
    for (int k = 0; k < 520; k++) begin
      if (ce2 === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL max_ce: ce=1 want 0 at cycle %0d", k); end
        else begin
          e = exp_q.pop_front();
          if (32'(k) !== e) begin errors++; $display("FAIL max_ce: at cycle %0d want cycle %0d", k, e); end
        end
      end
      if (done2 === 1'b1 && done_k < 0) done_k = k;
      if (k == 2) begin
        checks++; if (q2 !== 8'd255) begin errors++; $display("FAIL max_load: q=%0d want 255", q2); end
      end
      if (k > 2 && !(q2 == prev || q2 == prev - 8'd1)) bad++;
      prev = q2;
      step();
    end
    checks++; if (bad != 0 || q2 !== '0) begin errors++; $display("FAIL max_mono: bad_steps=%0d final_q=%0d want 0 0", bad, q2); end
    checks++; if (done_k !== 514 || exp_q.size() != 0) begin errors++; $display("FAIL max_done: done_cycle=%0d missing ce=%0d want 514 0", done_k, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_pause();
    test_auto();
    test_abort();
    test_back_to_back();
    test_period_zero();
    test_period_max();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
